ddr_burst_fetch: RTL and testbench
==================================

# ddr_burst_fetch

Sequential read client for one channel of the DDR read service. It turns a start address and a length into a series of toggle-handshake burst requests and buffers the returned 64-bit words in a FIFO. It then streams them to the core as 16-bit words under valid/ready flow control. It sits directly upstream of the service's `chN_*` port and feeds from the data that port returns.

## Interface
Parameters:
- `BURST`, default 32: maximum words (64-bit) per request; legal range 1..128.
- `AW`, default 7: log2 of FIFO depth in 64-bit words. Depth (`2**AW`) must be ≥ `BURST`.

Ports:
- `clk`  in  1  single clock. Everything is synchronous to its rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a transfer; ignored while `busy`=1.
- `start_addr`  in  29 [31:3]  first 64-bit word address.
- `length`  in  24  transfer length in 64-bit words.
- `busy`  out  1  high from acceptance of `start` until the last 16-bit word is accepted.
- `ddr_addr`  out  29 [31:3]  to service `chN_addr`.
- `ddr_burst`  out  8  to service `chN_burst`.
- `ddr_req`  out  1  to service `chN_req`; each toggle is one request.
- `ddr_data`  in  64  from service `chN_data`.
- `ddr_ready`  in  1  from service `chN_ready`; one-cycle strobe per valid word.
- `out_data`  out  16  output word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_valid` and `out_ready` are both 1.

## Operation
- State machine: IDLE, FETCH, WAIT, DRAIN.
- **IDLE**
  - `start` with `length`≠0: latch `cur_addr`=`start_addr` and `remain`=`length`, set `busy`, go to FETCH.
  - `start` with `length`=0: ignored.
- **FETCH**
  - `remain`=0: go to DRAIN.
  - Otherwise compute `n`=min(`BURST`,`remain`). If free FIFO space (`2**AW` − fill) ≥ `n`: toggle `ddr_req`, drive `ddr_addr`=`cur_addr` and `ddr_burst`=`n`, load `rx_cnt`=`n`, go to WAIT.
  - If space is insufficient, stay in FETCH with no toggle.
- **WAIT**
  - Each `ddr_ready` pushes `ddr_data` into the FIFO and decrements `rx_cnt`.
  - On the last word (`rx_cnt`=1 and `ddr_ready`): `cur_addr`+=`n` (29-bit, wraps modulo 2^29), `remain`−=`n`, go to FETCH.
  - Only one request is outstanding at any time. The toggle protocol forbids a second toggle before the burst completes.
- **DRAIN**: when the FIFO is empty, the serializer is empty and the final output word has been accepted: clear `busy`, go to IDLE.
- `ddr_ready` outside WAIT is discarded and never written to the FIFO.
- Serializer: holds one 64-bit word and emits lanes [15:0], [31:16], [47:32], [63:48] in that order.
  - Advances one lane per accepted transfer.
  - Loads the next FIFO word in the same cycle the last lane is accepted (no bubble when data is available).
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- FIFO overflow is impossible by construction (the space check). The bench asserts no write occurs when the FIFO is full.

## Timing
- Reset values:
  - `busy`=0, `out_valid`=0, `out_data`=0, `ddr_addr`=0, `ddr_burst`=0.
  - FIFO empty, state IDLE.
  - `ddr_req` is **not** changed by reset; it powers up 0. Forcing it would issue a phantom request whenever the service's ack is 1.
- `start` sampled high at edge N: `busy`=1 after N; the first `ddr_req` toggle is visible after edge N+1 (FETCH has one cycle of decision latency).
- `ddr_addr` and `ddr_burst` change only together with a `ddr_req` toggle, and stay stable until the next toggle.
- After the last word of a burst at edge M: state is FETCH after M. The next toggle is visible after M+1 if space allows (2-cycle minimum gap between bursts).
- FIFO write to `out_valid`: with the serializer empty, a word written at edge K gives `out_valid`=1 after edge K+2.
- Reset mid-operation: all state is dropped immediately. Later `ddr_ready` strobes from an in-flight burst are discarded while IDLE/FETCH. Software must not pulse `start` until the in-flight burst would have completed (≤ `BURST` service cycles).
- Simultaneous FIFO push and pop in one cycle: fill count unchanged.

## Test plan
- `length`=8, `start_addr`=0x100, `BURST`=32 → one toggle with `ddr_burst`=8, `ddr_addr`=0x100. Then 32 output words in lane order, then `busy` falls; `ddr_req` toggled exactly once.
- `length`=70, `BURST`=32 → three requests: (0x100,32), (0x120,32), (0x140,6). 280 output words in order; requests never overlap.
- `out_ready` held 0, `length`=300, `AW`=7 → exactly 4 requests (128 words), then no toggle. Release `out_ready`: the 5th request is issued once 32 words of space free up; all 1200 words are correct.
- `length`=0 → no toggle, `busy` stays 0. `start` pulsed while `busy`=1 → ignored; address sequence is unchanged.
- `reset_n` low for 1 cycle mid-WAIT with remaining `ddr_ready` strobes still arriving → `out_valid`=0, `busy`=0, FIFO empty, `ddr_req` level preserved. The next legal `start` produces exactly one toggle and correct data.
- Random `out_ready` (50%) with `length`=1000 → output matches the memory model word-for-word and `out_data` stays stable during stalls.

Source files
------------

// File: rtl/ddr_burst_fetch.sv
// ddr_burst_fetch: sequential read client for one DDR service channel.
// Issues toggle-handshake burst requests, buffers the returned 64-bit words
// in a FIFO and streams them to the core as 16-bit lanes, low lane first,
// under valid/ready flow control.
module ddr_burst_fetch #(
  parameter int BURST = 32,
  parameter int AW    = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [28:0] start_addr,
  input  logic [23:0] length,
  output logic        busy,
  output logic [28:0] ddr_addr,
  output logic [7:0]  ddr_burst,
  output logic        ddr_req,
  input  logic [63:0] ddr_data,
  input  logic        ddr_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  // Selects one 16-bit lane of a 64-bit word.
  function automatic logic [15:0] lane_sel(input logic [63:0] w, input logic [1:0] l);
    logic [15:0] r;
    case (l)
      2'd0:    r = w[15:0];
      2'd1:    r = w[31:16];
      2'd2:    r = w[47:32];
      default: r = w[63:48];
    endcase
    return r;
  endfunction

  state_t      state;
  logic [28:0] cur_addr;
  logic [23:0] remain;
  logic [7:0]  rx_cnt;
  // ddr_req must never be disturbed by reset: a forced level would look like
  // a request to the service. It powers up low and only ever toggles.
  logic        req_q = 1'b0;

  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic [AW:0]   space;

  // FIFO output register (first stage) and serializer (second stage)
  logic [63:0] word_p0;
  logic        vld_p0;
  logic [63:0] sh_p1;
  logic [1:0]  lane;

  logic [7:0]  n_burst;
  logic        space_ok;
  logic        push;
  logic        pop;
  logic        accept;
  logic        last_lane;
  logic        ser_load;
  logic        drain_done;

  assign ddr_req    = req_q;
  assign space      = DEPTH_V - fill;
  assign n_burst    = (remain >= 24'(BURST)) ? 8'(BURST) : remain[7:0];
  assign space_ok   = 32'(space) >= 32'(n_burst);
  assign push       = (state == WAIT) && ddr_ready;
  assign accept     = out_valid && out_ready;
  assign last_lane  = (lane == 2'd3);
  // Serializer takes a new word when empty or when its last lane leaves now.
  assign ser_load   = vld_p0 && (!out_valid || (accept && last_lane));
  // Output register refills from memory when empty or being consumed.
  assign pop        = (fill != '0) && (!vld_p0 || ser_load);
  assign drain_done = (fill == '0) && !vld_p0 && (!out_valid || (accept && last_lane));

  // Request sequencer: one outstanding burst, gated by free FIFO space.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ddr_addr  <= '0;
      ddr_burst <= '0;
      cur_addr  <= '0;
      remain    <= '0;
      rx_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (length != '0)) begin
            cur_addr <= start_addr;
            remain   <= length;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (remain == '0) begin
            state <= DRAIN;
          end else if (space_ok) begin
            req_q     <= ~req_q;
            ddr_addr  <= cur_addr;
            ddr_burst <= n_burst;
            rx_cnt    <= n_burst;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (ddr_ready) begin
            rx_cnt <= rx_cnt - 8'd1;
            if (rx_cnt == 8'd1) begin
              cur_addr <= cur_addr + 29'(ddr_burst);
              remain   <= remain - 24'(ddr_burst);
              state    <= FETCH;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ddr_data;
  end

  // FIFO pointers, fill count and output-register valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
      if (pop)           vld_p0 <= 1'b1;
      else if (ser_load) vld_p0 <= 1'b0;
    end
  end

  // FIFO output register data.
  always_ff @(posedge clk) begin
    if (pop) word_p0 <= mem[rd_ptr];
  end

  // Serializer word holding register.
  always_ff @(posedge clk) begin
    if (ser_load) sh_p1 <= word_p0;
  end

  // Lane sequencing and registered output; data holds while stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      lane      <= '0;
    end else if (ser_load) begin
      out_valid <= 1'b1;
      out_data  <= word_p0[15:0];
      lane      <= 2'd0;
    end else if (accept) begin
      if (last_lane) begin
        out_valid <= 1'b0;
      end else begin
        lane     <= lane + 2'd1;
        out_data <= lane_sel(sh_p1, lane + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_fetch.sv
// Directed bench for ddr_burst_fetch: a DDR service model answering toggle
// requests from an address-derived memory image, a consumer capturing the
// 16-bit stream, and one task per scenario.
`timescale 1ns/1ps
module tb_ddr_burst_fetch;

  localparam int BURST = 32;
  localparam int AW    = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [28:0] start_addr = '0;
  logic [23:0] length = '0;
  logic        busy;
  logic [28:0] ddr_addr;
  logic [7:0]  ddr_burst;
  logic        ddr_req;
  logic [63:0] ddr_data = '0;
  logic        ddr_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // service model state
  logic        prev_req = 1'b0;
  logic [28:0] svc_addr = '0;
  int          svc_left = 0;
  bit          gap_mode = 1'b0;
  bit          phase = 1'b0;
  logic [28:0] rq_addr[$];
  logic [7:0]  rq_burst[$];
  int          overlap_err = 0;

  // consumer state
  int          ready_mode = 1;
  logic [15:0] got[$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  int          stall_viol = 0;
  int          ovf = 0;

  ddr_burst_fetch #(.BURST(BURST), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .ddr_addr(ddr_addr), .ddr_burst(ddr_burst),
    .ddr_req(ddr_req), .ddr_data(ddr_data), .ddr_ready(ddr_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lane_val(input logic [28:0] a, input logic [1:0] i);
    return {a[13:0], i} ^ 16'hA55A;
  endfunction

  function automatic logic [63:0] word_val(input logic [28:0] a);
    return {lane_val(a, 2'd3), lane_val(a, 2'd2), lane_val(a, 2'd1), lane_val(a, 2'd0)};
  endfunction

  function automatic int count_bad(input logic [28:0] base, input int n, output int first);
    int bad;
    bad = 0;
    first = -1;
    for (int i = 0; i < n && i < got.size(); i++) begin
      logic [28:0] a;
      logic [1:0]  li;
      a  = base + 29'(i >> 2);
      li = 2'(i);
      if (got[i] !== lane_val(a, li)) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    return bad;
  endfunction

  // DDR service: one toggle = one request, words returned one per strobe.
  initial begin
    forever begin
      @(posedge clk); #1;
      ddr_ready = 1'b0;
      phase = ~phase;
      if (ddr_req !== prev_req) begin
        prev_req = ddr_req;
        if (svc_left != 0) overlap_err++;
        svc_addr = ddr_addr;
        svc_left = int'(ddr_burst);
        rq_addr.push_back(ddr_addr);
        rq_burst.push_back(ddr_burst);
      end else if (svc_left > 0 && (!gap_mode || phase)) begin
        ddr_ready = 1'b1;
        ddr_data  = word_val(svc_addr);
        svc_addr  = svc_addr + 29'd1;
        svc_left  = svc_left - 1;
      end
    end
  end

  // Consumer ready pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Capture accepted words, watch stall stability and FIFO writes when full.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_viol++;
        if (out_valid && out_ready) got.push_back(out_data);
        if (dut.push && dut.fill == 8'(1 << AW)) ovf++;
      end
      prev_stall = reset_n && out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [28:0] a, input logic [23:0] l);
    @(posedge clk); #1;
    start_addr = a;
    length     = l;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < limit) begin
      @(negedge clk);
      c++;
    end
    ok = !busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (ddr_addr !== 29'h0) begin n_err++; $display("FAIL reset_ddr_addr: got %h want 0", ddr_addr); end
    n_cmp++; if (ddr_burst !== 8'h0) begin n_err++; $display("FAIL reset_ddr_burst: got %h want 0", ddr_burst); end
    n_cmp++; if (ddr_req !== 1'b0) begin n_err++; $display("FAIL reset_ddr_req: got %b want 0", ddr_req); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    int b, bad, first;
    logic lvl;
    bit ok;
    ready_mode = 1; gap_mode = 1'b0;
    got.delete();
    b   = rq_addr.size();
    lvl = ddr_req;
    pulse_start(29'h100, 24'd8);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_rise: got %b want 1", busy); end
    n_cmp++; if (ddr_req !== lvl) begin n_err++; $display("FAIL single_no_early_toggle: got %b want %b", ddr_req, lvl); end
    @(posedge clk); #1;
    n_cmp++; if (ddr_req !== ~lvl) begin n_err++; $display("FAIL single_toggle: got %b want %b", ddr_req, ~lvl); end
    n_cmp++; if (ddr_addr !== 29'h100) begin n_err++; $display("FAIL single_addr: got %h want 100", ddr_addr); end
    n_cmp++; if (ddr_burst !== 8'd8) begin n_err++; $display("FAIL single_burst: got %0d want 8", ddr_burst); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_latency: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== lane_val(29'h100, 2'd0)) begin n_err++; $display("FAIL single_first_lane: got %h want %h", out_data, lane_val(29'h100, 2'd0)); end
    wait_idle(500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_idle: busy still %b want 0", busy); end
    n_cmp++; if (got.size() !== 32) begin n_err++; $display("FAIL single_count: got %0d words want 32", got.size()); end
    bad = count_bad(29'h100, 32, first);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL single_data: %0d bad words (first %0d) want 0", bad, first); end
    n_cmp++; if (rq_addr.size() - b !== 1) begin n_err++; $display("FAIL single_req_count: got %0d want 1", rq_addr.size() - b); end
  endtask

  task automatic test_multi();
    int b, bad, first, ov;
    bit ok;
    logic [28:0] ea [3];
    logic [7:0]  eb [3];
    ea = '{29'h100, 29'h120, 29'h140};
    eb = '{8'd32, 8'd32, 8'd6};
    ready_mode = 1; gap_mode = 1'b0;
    got.delete();
    b  = rq_addr.size();
    ov = overlap_err;
    pulse_start(29'h100, 24'd70);
    wait_idle(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL multi_idle: busy still %b want 0", busy); end
    n_cmp++; if (rq_addr.size() - b !== 3) begin n_err++; $display("FAIL multi_req_count: got %0d want 3", rq_addr.size() - b); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (rq_addr[b+k] !== ea[k] || rq_burst[b+k] !== eb[k]) begin
        n_err++;
        $display("FAIL multi_req%0d: got (%h,%0d) want (%h,%0d)", k, rq_addr[b+k], rq_burst[b+k], ea[k], eb[k]);
      end
    end
    n_cmp++; if (got.size() !== 280) begin n_err++; $display("FAIL multi_count: got %0d words want 280", got.size()); end
    bad = count_bad(29'h100, 280, first);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL multi_data: %0d bad words (first %0d) want 0", bad, first); end
    n_cmp++; if (overlap_err - ov !== 0) begin n_err++; $display("FAIL multi_overlap: got %0d want 0", overlap_err - ov); end
  endtask

  task automatic test_backpressure();
    int b, bad, first;
    bit ok;
    ready_mode = 0; gap_mode = 1'b0;
    got.delete();
    b = rq_addr.size();
    pulse_start(29'h100, 24'd300);
    repeat (600) @(negedge clk);
    n_cmp++; if (rq_addr.size() - b !== 4) begin n_err++; $display("FAIL bp_req_stalled: got %0d requests want 4", rq_addr.size() - b); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b want 1", busy); end
    ready_mode = 1;
    wait_idle(5000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_idle: busy still %b want 0", busy); end
    n_cmp++; if (rq_addr.size() - b !== 10) begin n_err++; $display("FAIL bp_req_total: got %0d want 10", rq_addr.size() - b); end
    n_cmp++; if (rq_addr[b+4] !== 29'h180 || rq_burst[b+4] !== 8'd32) begin n_err++; $display("FAIL bp_req5: got (%h,%0d) want (180,32)", rq_addr[b+4], rq_burst[b+4]); end
    n_cmp++; if (rq_addr[b+9] !== 29'h220 || rq_burst[b+9] !== 8'd12) begin n_err++; $display("FAIL bp_req10: got (%h,%0d) want (220,12)", rq_addr[b+9], rq_burst[b+9]); end
    n_cmp++; if (got.size() !== 1200) begin n_err++; $display("FAIL bp_count: got %0d words want 1200", got.size()); end
    bad = count_bad(29'h100, 1200, first);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_data: %0d bad words (first %0d) want 0", bad, first); end
  endtask

  task automatic test_zero_and_ignored_start();
    int b, bad, first;
    logic lvl;
    bit ok;
    ready_mode = 1; gap_mode = 1'b0;
    got.delete();
    b   = rq_addr.size();
    lvl = ddr_req;
    pulse_start(29'h55, 24'd0);
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy); end
    n_cmp++; if (ddr_req !== lvl || rq_addr.size() != b) begin n_err++; $display("FAIL zero_no_toggle: req %b want %b, %0d new requests", ddr_req, lvl, rq_addr.size() - b); end
    pulse_start(29'h2000, 24'd40);
    repeat (8) @(posedge clk);
    pulse_start(29'h7777, 24'd5);
    wait_idle(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ign_idle: busy still %b want 0", busy); end
    n_cmp++; if (rq_addr.size() - b !== 2) begin n_err++; $display("FAIL ign_req_count: got %0d want 2", rq_addr.size() - b); end
    n_cmp++; if (rq_addr[b] !== 29'h2000 || rq_burst[b] !== 8'd32) begin n_err++; $display("FAIL ign_req1: got (%h,%0d) want (2000,32)", rq_addr[b], rq_burst[b]); end
    n_cmp++; if (rq_addr[b+1] !== 29'h2020 || rq_burst[b+1] !== 8'd8) begin n_err++; $display("FAIL ign_req2: got (%h,%0d) want (2020,8)", rq_addr[b+1], rq_burst[b+1]); end
    n_cmp++; if (got.size() !== 160) begin n_err++; $display("FAIL ign_count: got %0d words want 160", got.size()); end
    bad = count_bad(29'h2000, 160, first);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ign_data: %0d bad words (first %0d) want 0", bad, first); end
  endtask

  task automatic test_reset_mid_wait();
    int b, c, bad, first;
    logic lvl;
    bit ok;
    ready_mode = 1; gap_mode = 1'b0;
    pulse_start(29'h300, 24'd64);
    c = 0;
    @(negedge clk);
    while (!(svc_left > 0 && svc_left <= 20) && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_cmp++; if (svc_left <= 0 || svc_left > 20) begin n_err++; $display("FAIL rst_mid_reach: svc_left %0d want 1..20", svc_left); end
    lvl = ddr_req;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    got.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_cmp++; if (dut.fill !== '0) begin n_err++; $display("FAIL rst_mid_fill: got %0d want 0", dut.fill); end
    n_cmp++; if (ddr_req !== lvl) begin n_err++; $display("FAIL rst_mid_req_level: got %b want %b", ddr_req, lvl); end
    c = 0;
    while (svc_left != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (dut.fill !== '0 || out_valid !== 1'b0 || got.size() != 0) begin n_err++; $display("FAIL rst_mid_discard: fill %0d valid %b words %0d want 0 0 0", dut.fill, out_valid, got.size()); end
    b = rq_addr.size();
    pulse_start(29'h500, 24'd4);
    wait_idle(500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_next_idle: busy still %b want 0", busy); end
    n_cmp++; if (rq_addr.size() - b !== 1 || rq_addr[b] !== 29'h500 || rq_burst[b] !== 8'd4) begin n_err++; $display("FAIL rst_next_req: %0d requests first (%h,%0d) want 1 (500,4)", rq_addr.size() - b, rq_addr[b], rq_burst[b]); end
    n_cmp++; if (got.size() !== 16) begin n_err++; $display("FAIL rst_next_count: got %0d words want 16", got.size()); end
    bad = count_bad(29'h500, 16, first);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_next_data: %0d bad words (first %0d) want 0", bad, first); end
  endtask

  task automatic test_random_ready();
    int b, bad, first, sv, ov;
    bit ok;
    ready_mode = 2; gap_mode = 1'b1;
    got.delete();
    b  = rq_addr.size();
    sv = stall_viol;
    ov = overlap_err;
    pulse_start(29'h1FFF_FFF0, 24'd1000);
    wait_idle(30000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rand_idle: busy still %b want 0", busy); end
    n_cmp++; if (rq_addr.size() - b !== 32) begin n_err++; $display("FAIL rand_req_count: got %0d want 32", rq_addr.size() - b); end
    n_cmp++; if (rq_addr[b+1] !== 29'h10 || rq_burst[b+1] !== 8'd32) begin n_err++; $display("FAIL rand_req_wrap: got (%h,%0d) want (10,32)", rq_addr[b+1], rq_burst[b+1]); end
    n_cmp++; if (rq_addr[b+31] !== 29'h3D0 || rq_burst[b+31] !== 8'd8) begin n_err++; $display("FAIL rand_req_last: got (%h,%0d) want (3d0,8)", rq_addr[b+31], rq_burst[b+31]); end
    n_cmp++; if (got.size() !== 4000) begin n_err++; $display("FAIL rand_count: got %0d words want 4000", got.size()); end
    bad = count_bad(29'h1FFF_FFF0, 4000, first);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rand_data: %0d bad words (first %0d) want 0", bad, first); end
    n_cmp++; if (stall_viol - sv !== 0) begin n_err++; $display("FAIL rand_stall_stable: %0d violations want 0", stall_viol - sv); end
    n_cmp++; if (overlap_err - ov !== 0) begin n_err++; $display("FAIL rand_overlap: got %0d want 0", overlap_err - ov); end
    ready_mode = 1; gap_mode = 1'b0;
  endtask

  task automatic test_integrity();
    n_cmp++; if (ovf !== 0) begin n_err++; $display("FAIL fifo_full_write: %0d writes while full want 0", ovf); end
    n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL stall_stable_total: %0d violations want 0", stall_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_zero_and_ignored_start();
    test_reset_mid_wait();
    test_random_ready();
    test_integrity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
